// File: rtl/weight_streamer.sv
// Streams a burst of ROM words (base_addr, count) out over a valid/ready port.
// Latency: first beat 4 cycles after the start edge; then 1 beat/cycle with out_ready high.
// Backpressure: address issue is throttled so FIFO + in-flight reads never exceed 4 words.
//
// Ports: clk/rst (sync, active-high); start/base_addr/count request a burst in IDLE;
// rom_addr/rom_data form a 2-cycle-latency ROM read port; out_data/out_valid/out_ready/
// out_last carry the stream; busy covers the burst, done pulses once at its end.
module weight_streamer #(
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 1024,
    localparam int AW = $clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [AW:0]          count,
    output logic [AW-1:0]        rom_addr,
    input  logic [RAM_WIDTH-1:0] rom_data,
    output logic [RAM_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]           state;
    logic [AW-1:0]        next_addr;   // next address to issue
    logic [AW:0]          issue_left;  // addresses still to issue
    logic [AW:0]          out_left;    // beats still to deliver
    // pipe_vld[0] travels with rom_addr, [2] lines up with rom_data of that read.
    logic [2:0]           pipe_vld;

    logic [RAM_WIDTH-1:0] fifo_mem [0:3];
    logic [1:0]           wr_ptr;
    logic [1:0]           rd_ptr;
    logic [2:0]           occ;

    logic                 push;
    logic                 pop;
    logic                 issue;
    logic [1:0]           in_flight;
    logic [3:0]           committed;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
        // Explicit wrap so non-power-of-2 depths roll over correctly.
        return (a == AW'(RAM_DEPTH - 1)) ? '0 : a + AW'(1);
    endfunction

    assign out_valid = (occ != 3'd0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    assign out_last  = out_valid && (out_left == (AW+1)'(1));
    assign busy      = (state != S_IDLE);

    assign pop       = out_valid && out_ready;
    assign push      = pipe_vld[2];
    assign in_flight = {1'b0, pipe_vld[0]} + {1'b0, pipe_vld[1]} + {1'b0, pipe_vld[2]};
    assign committed = {1'b0, occ} + {2'b0, in_flight};
    // Every issued read is guaranteed a FIFO slot when it returns; a pop this cycle frees one.
    assign issue     = (state == S_FETCH) && (committed < (pop ? 4'd5 : 4'd4));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            next_addr  <= '0;
            issue_left <= '0;
            out_left   <= '0;
            pipe_vld   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            rom_addr   <= '0;
            done       <= 1'b0;
        end else begin
            done     <= 1'b0;
            pipe_vld <= {pipe_vld[1:0], issue};

            if (issue) begin
                rom_addr   <= next_addr;
                next_addr  <= wrap_inc(next_addr);
                issue_left <= issue_left - (AW+1)'(1);
            end

            if (push) begin
                fifo_mem[wr_ptr] <= rom_data;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 2'd1;
                out_left <= out_left - (AW+1)'(1);
            end
            occ <= occ + {2'b0, push} - {2'b0, pop};

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state      <= S_FETCH;
                            next_addr  <= base_addr;
                            issue_left <= count;
                            out_left   <= count;
                        end
                    end
                end
                S_FETCH: begin
                    if (issue && issue_left == (AW+1)'(1))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop && out_last) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
